// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of decode.
//
// Owns the program counter and drives a synchronous instruction memory
// (one-cycle read latency). Fetched words are queued with their PC in a
// small FIFO. The FIFO head goes to decode over a valid/ready handshake.
// A redirect from the control path flushes the FIFO, drops any response
// still returning, and restarts fetch at the target.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   imem_req         fetch request this cycle
//   imem_addr        word-aligned byte address of the request
//   imem_rdata       instruction word, valid the cycle after imem_req
//   redirect         taken branch / jump from control
//   redirect_target  new PC for the redirect; low two bits are ignored
//   instr            head instruction, or NOP when the FIFO is empty
//   pc, pc_plus4     PC of the head instruction and PC + 4
//   instr_valid      head entry is valid
//   instr_ready      decode accepts the head this cycle
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  instr_valid,
    input  logic                  instr_ready
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic                  kill_q, kill_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] last_pc_q;
    logic [DATA_WIDTH-1:0] rsp_pc_q;
    logic [DATA_WIDTH-1:0] buf_instr_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc_q    [BUF_DEPTH];

    logic          pop, push;
    logic [OW-1:0] occ;

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready;
    // A response arriving in a redirect cycle belongs to the old path.
    assign push        = inflight_q & ~kill_q & ~redirect;

    // Occupancy if we issue now: the in-flight word already owns a slot,
    // and a pop this cycle frees one. This is what makes overflow impossible.
    assign occ      = OW'(count_q) + OW'(inflight_q) - OW'(pop);
    assign imem_req = rst_n & ~redirect & (occ < OW'(BUF_DEPTH));
    assign imem_addr = fetch_pc_q;

    assign instr    = instr_valid ? buf_instr_q[rd_ptr_q] : NOP;
    assign pc       = instr_valid ? buf_pc_q[rd_ptr_q]    : last_pc_q;
    assign pc_plus4 = pc + DATA_WIDTH'(4);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = imem_req;
        kill_d     = redirect & inflight_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        if (redirect) begin
            fetch_pc_d = redirect_target & ~DATA_WIDTH'(3);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            last_pc_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            // Remember the last presented PC so pc holds while empty.
            if (instr_valid) last_pc_q <= buf_pc_q[rd_ptr_q];
        end
    end

    // Data path needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (imem_req) rsp_pc_q <= imem_addr;
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a ROM model answers fetches, and a
// scoreboard queue holds the PC stream decode should see after each reset
// or redirect; every accepted head is popped and compared against it.
module tb_fetch_unit;
    localparam int          DW     = 32;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] NOP    = 32'h13;

    logic        clk, rst_n;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instr, pc, pc_plus4;
    logic        instr_valid, instr_ready;

    fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    initial imem_rdata = 32'hDEAD_BEEF;
    always @(posedge clk) if (imem_req) imem_rdata <= rom(imem_addr);

    int checks = 0, failures = 0, delivered = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected PC stream, re-seeded on reset and redirect.
    logic [31:0] exp_q [$];
    logic [31:0] next_push = RST_PC;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("req_in_reset", {31'b0, imem_req}, 32'h0);
            exp_q.delete();
            next_push = RST_PC;
        end else begin
            if (!instr_valid) chk("nop_when_empty", instr, NOP);
            if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
            while (exp_q.size() < 4) begin
                exp_q.push_back(next_push);
                next_push = next_push + 32'd4;
            end
            if (instr_valid && instr_ready) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", pc, e);
                chk("sb_instr", instr, rom(e));
                chk("sb_pc_plus4", pc_plus4, e + 32'd4);
                delivered++;
            end
            // The pop above still counts; everything after it is flushed.
            if (redirect) begin
                exp_q.delete();
                next_push = redirect_target & ~32'd3;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        chk(tag, {31'b0, instr_valid}, 32'h1);
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] p);
        for (int i = 0; i < 40 && !(instr_valid && pc == p); i++) step();
        chk(tag, pc, p);
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect = 1'b1;
        redirect_target = t;
        #1;
        chk("no_req_on_redirect", {31'b0, imem_req}, 32'h0);
        step();
        redirect = 1'b0;
        #1;
        chk("flushed_after_redirect", {31'b0, instr_valid}, 32'h0);
        chk("req_target", {31'b0, imem_req}, 32'h1);
        chk("addr_target", imem_addr, t & ~32'd3);
    endtask

    initial begin
        rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_target = '0;
        repeat (3) step();

        // Reset state
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);

        // 1: two-cycle latency, then one instruction per cycle
        rst_n = 1'b1;
        #1;
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, RST_PC);
        step();
        chk("lat_c1_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("lat_c2_valid", {31'b0, instr_valid}, 32'h1);
        chk("lat_c2_pc", pc, RST_PC);
        step();
        chk("thru_valid1", {31'b0, instr_valid}, 32'h1);
        chk("thru_pc1", pc, 32'h4);

        // 3: redirect while pc=8 is at the head
        wait_pc("wait_pc8", 32'h8);
        do_redirect(32'h40);
        wait_valid("valid_after_redirect");
        chk("pc_after_redirect", pc, 32'h40);
        repeat (4) step();

        // 4: misaligned target is silently aligned
        do_redirect(32'h43);
        wait_valid("valid_after_misaligned");
        chk("pc_misaligned", pc, 32'h40);
        repeat (3) step();

        // 5: PC wraps at the top of the address space
        do_redirect(32'hFFFF_FFF8);
        wait_pc("wait_pc_top", 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        step();
        chk("wrap_pc", pc, 32'h0);
        repeat (4) step();

        // 2: decode stalls from the first valid; fetch must back off
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; instr_ready = 1'b0;
        wait_valid("stall_first_valid");
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", {31'b0, imem_req}, 32'h0);
            chk("stall_pc", pc, RST_PC);
            chk("stall_instr", instr, rom(RST_PC));
            step();
        end
        instr_ready = 1'b1;
        repeat (8) step();

        // 6: reset while streaming with a fetch in flight
        instr_ready = 1'b0; rst_n = 1'b0;
        step();
        chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
        chk("midrst_instr", instr, NOP);
        chk("midrst_pc", pc, 32'h0);
        rst_n = 1'b1; instr_ready = 1'b1;
        wait_valid("midrst_restart");
        chk("midrst_first_pc", pc, RST_PC);
        repeat (6) step();

        chk("delivered_enough", {31'b0, delivered > 30}, 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decode/register-file/control block. It owns the program counter and drives a synchronous instruction memory. It buffers fetched words in a small FIFO and presents {instr, pc, pc_plus4} to decode over a valid/ready handshake. Branch and jump redirects arrive from the control path; on a redirect the block flushes all buffered and in-flight fetches and restarts at the target.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction.
RESET_PC, 32'h0000_0000, PC fetched first after reset.
BUF_DEPTH, 2, instruction FIFO entries (power of two, >=2).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous reset, active-low.
imem_req  out  1  fetch request this cycle.
imem_addr  out  DATA_WIDTH  byte address of the request; bits[1:0] always 0.
imem_rdata  in  DATA_WIDTH  instruction word, valid the cycle after the request.
redirect  in  1  taken branch or jump (PCSrc | Jump) from control.
redirect_target  in  DATA_WIDTH  new PC for a redirect.
instr  out  DATA_WIDTH  head instruction to decode.
pc  out  DATA_WIDTH  PC of the head instruction.
pc_plus4  out  DATA_WIDTH  pc + 4, modulo 2^DATA_WIDTH.
instr_valid  out  1  head entry is valid.
instr_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset (rst_n low at an edge):
  - fetch_pc <= RESET_PC; FIFO count = 0; inflight = 0; kill = 0.
  - Outputs after reset: instr_valid = 0, instr = 32'h0000_0013 (NOP), pc = 0, pc_plus4 = 4, imem_req = 0 while rst_n is low.
  - Reset asserted mid-operation discards everything, including in-flight data, with no partial output.
- Issue:
  - imem_req = rst_n & ~redirect & ((count + inflight - pop) < BUF_DEPTH), where pop = instr_valid & instr_ready.
  - imem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4 (wraps 0xFFFF_FFFC -> 0) and inflight <= 1 for the next cycle; otherwise inflight <= 0.
  - imem_req depends combinationally on instr_ready and redirect; this path is accepted.
- Response:
  - The cycle after an issue, imem_rdata is pushed into the FIFO together with its PC (a registered copy of imem_addr), unless kill = 1.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Output:
  - instr_valid = (count != 0); instr, pc and pc_plus4 come from the FIFO head.
  - instr = NOP and pc/pc_plus4 hold their last values when count = 0.
  - Head and pc are stable while instr_valid & ~instr_ready.
- Latency:
  - Request in cycle C0, data in C1, instr_valid high in C2 (2 cycles to first instruction).
  - Sustained throughput is 1 instruction/cycle with instr_ready held high and BUF_DEPTH >= 2.
- Redirect (sampled at the edge):
  - FIFO flushed (count <= 0).
  - fetch_pc <= {redirect_target[DATA_WIDTH-1:2], 2'b00}; misaligned low bits are silently cleared.
  - kill <= inflight, so a response returning next cycle is dropped.
  - No request is issued in the redirect cycle; the first fetch of the target happens in the next cycle.
  - Redirect beats a simultaneous pop: the popped instruction is still consumed by decode that cycle, but no further entries survive.
  - Back-to-back redirects: the last one wins.
- Boundaries:
  - FIFO full: no issue, and no overflow is possible because the issue condition counts inflight.
  - FIFO empty with instr_ready high: no pop.
  - Pointers wrap modulo BUF_DEPTH.

Test Plan:
1. Release reset with RESET_PC=0, ROM word[i]=0x1000+i, instr_ready=1 -> instr_valid rises 2 cycles after release; then pc = 0,4,8,... every cycle; instr = 0x1000, 0x1001, ...; pc_plus4 = pc+4.
2. Hold instr_ready=0 for 5 cycles after the first valid -> imem_req drops once count+inflight=2; head stays pc=0 and instr=0x1000. On release, pc=0,4,8 are delivered in order with no loss and no duplicate.
3. While streaming, assert redirect with target 0x40 in the cycle pc=8 is at the head -> next edge instr_valid=0. Request to 0x40 issued the following cycle; the next delivered pc is 0x40. Words for 0x0C/0x10 are never presented.
4. Redirect with target 0x43 -> imem_addr=0x40 and the delivered pc=0x40.
5. Start at RESET_PC=0xFFFF_FFF8 -> delivered pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; pc_plus4 at 0xFFFF_FFFC is 0.
6. Assert rst_n=0 for one cycle while the FIFO is full and a fetch is in flight -> next cycle instr_valid=0, instr=0x13; restart from RESET_PC with no stale instruction delivered.
